// File: rtl/port_select_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hydra_sel_pkg                                                    |
// | Purpose : Shared constants and state encoding for the port select          |
// |           generator and its decoder.                                       |
// | Contents: PORTS, IDX_W, LEN_W constants; sel_state_t FSM encoding.         |
// | Options : none (the PORT_MASK_SEL_EN macro does not affect this package)   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package hydra_sel_pkg;

  localparam int PORTS = 32;             // number of switch ports, power of two
  localparam int IDX_W = $clog2(PORTS);  // width of a binary port index
  localparam int LEN_W = 8;              // width of the hold-length field

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sel_state_t;

endpackage
`default_nettype wire

// File: rtl/port_select_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_select_gen_if                                               |
// | Purpose : Request handshake and select bus of the port select generator.   |
// | Signals : in_valid/in_ready/in_idx/in_len  request channel                 |
// |           select/sel_valid/done            one-hot select output          |
// |           port_mask/drop                   masking (PORT_MASK_SEL_EN)     |
// | Modports: master = request producer / select consumer, slave = generator   |
// | Options : PORT_MASK_SEL_EN adds port_mask and drop                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface port_select_gen_if;
  import hydra_sel_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic [LEN_W-1:0] in_len;
  logic [PORTS-1:0] select;
  logic             sel_valid;
  logic             done;
`ifdef PORT_MASK_SEL_EN
  logic [PORTS-1:0] port_mask;
  logic             drop;
`endif

`ifdef PORT_MASK_SEL_EN
  modport master (
    output in_valid, in_idx, in_len, port_mask,
    input  in_ready, select, sel_valid, done, drop
  );
  modport slave (
    input  in_valid, in_idx, in_len, port_mask,
    output in_ready, select, sel_valid, done, drop
  );
`else
  modport master (
    output in_valid, in_idx, in_len,
    input  in_ready, select, sel_valid, done
  );
  modport slave (
    input  in_valid, in_idx, in_len,
    output in_ready, select, sel_valid, done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/port_select_gen_idx_to_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : idx_to_onehot                                                    |
// | Purpose : Purely combinational binary index to one-hot decoder.            |
// | Ports   : idx_i    [IDX_W-1:0]  binary port index                          |
// |           onehot_o [PORTS-1:0]  exactly one bit set, at position idx_i     |
// | Options : none                                                             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module idx_to_onehot #(
  parameter int IDX_W = 5,
  parameter int PORTS = 32
) (
  input  wire logic [IDX_W-1:0] idx_i,
  output      logic [PORTS-1:0] onehot_o
);

  // One comparator per output bit; PORTS is a power of two so every index
  // value maps to exactly one bit and the result is always one-hot.
  for (genvar i = 0; i < PORTS; i++) begin : g_dec
    assign onehot_o[i] = (idx_i == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/port_select_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : port_select_gen                                                  |
// | Purpose : Accepts a port index and hold length over valid/ready and drives |
// |           a registered one-hot select for in_len+1 cycles, with back-to-   |
// |           back grants possible in the last hold cycle.                     |
// | Ports   : clk        rising-edge clock                                     |
// |           rst_n      asynchronous active-low reset                         |
// |           bus        port_select_gen_if.slave (request + select signals)   |
// | Options : PORT_MASK_SEL_EN - requests to ports with port_mask set are      |
// |           consumed without a grant and reported with a drop pulse.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module port_select_gen
  import hydra_sel_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  port_select_gen_if.slave bus
);

  sel_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [PORTS-1:0] select_q, select_d;
  logic             sel_valid_q, sel_valid_d;

  logic [PORTS-1:0] w_onehot;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_masked;
  logic             w_grant;

  idx_to_onehot #(
    .IDX_W (IDX_W),
    .PORTS (PORTS)
  ) u_idx_to_onehot (
    .idx_i    (bus.in_idx),
    .onehot_o (w_onehot)
  );

  // Final hold cycle; also the only HOLD cycle in which a new request fits.
  assign w_last   = (state_q == HOLD) && (cnt_q == '0);
  // Depends on state/counter only so the producer may wait on it freely.
  assign w_ready  = (state_q == IDLE) || w_last;
  assign w_accept = bus.in_valid && w_ready;

`ifdef PORT_MASK_SEL_EN
  assign w_masked = bus.port_mask[bus.in_idx];
`else
  assign w_masked = 1'b0;
`endif

  assign w_grant = w_accept && !w_masked;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    select_d    = select_q;
    sel_valid_d = sel_valid_q;
    if (w_grant) begin
      state_d     = HOLD;
      cnt_d       = bus.in_len;
      select_d    = w_onehot;
      sel_valid_d = 1'b1;
    end else if (state_q == HOLD) begin
      // Covers both plain expiry and a discarded (masked) request arriving
      // in the last cycle: either way the hold ends and select clears.
      if (cnt_q == '0) begin
        state_d     = IDLE;
        select_d    = '0;
        sel_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      select_q    <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      select_q    <= select_d;
      sel_valid_q <= sel_valid_d;
    end
  end

`ifdef PORT_MASK_SEL_EN
  logic drop_q, drop_d;

  assign drop_d = w_accept && w_masked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop = drop_q;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.select    = select_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.done      = w_last;

endmodule
`default_nettype wire

// File: tb/tb_port_select_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_port_select_gen                                               |
// | Purpose : Directed self-checking bench for port_select_gen.                |
// | Options : PORT_MASK_SEL_EN enables the masked-port scenarios.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_port_select_gen;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  port_select_gen_if bus ();

  port_select_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, half a
  // period away from the rising edge the design acts on.
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_idx   = '0;
    bus.in_len   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
`ifdef PORT_MASK_SEL_EN
    bus.port_mask = '0;
`endif
    repeat (3) @(negedge clk);
    n_checks++; if (bus.select !== 32'h0) begin n_fail++; $display("FAIL reset_select got=%h exp=%h", bus.select, 32'h0); end
    n_checks++; if (bus.sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sel_valid got=%b exp=0", bus.sel_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
`ifdef PORT_MASK_SEL_EN
    n_checks++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got=%b exp=0", bus.drop); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.select !== 32'h0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle select=%h ready=%b done=%b exp 0/1/0", bus.select, bus.in_ready, bus.done);
    end
  endtask

  task automatic test_single_cycle();
    bus.in_valid = 1'b1; bus.in_idx = 5'd0; bus.in_len = 8'd0;
    @(negedge clk);
    idle_inputs();
    n_checks++; if (bus.select !== 32'h00000001) begin n_fail++; $display("FAIL single_select got=%h exp=%h", bus.select, 32'h1); end
    n_checks++; if (bus.sel_valid !== 1'b1) begin n_fail++; $display("FAIL single_sel_valid got=%b exp=1", bus.sel_valid); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL single_done got=%b exp=1", bus.done); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    n_checks++; if (bus.select !== 32'h0 || bus.sel_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL single_after select=%h sel_valid=%b done=%b exp 0/0/0", bus.select, bus.sel_valid, bus.done);
    end
  endtask

  task automatic test_long_hold();
    bus.in_valid = 1'b1; bus.in_idx = 5'd31; bus.in_len = 8'd3;
    @(negedge clk);
    // Index/length changes during the hold must be ignored.
    bus.in_valid = 1'b0; bus.in_idx = 5'd3; bus.in_len = 8'd9;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.select !== 32'h80000000) begin n_fail++; $display("FAIL long_select[%0d] got=%h exp=%h", k, bus.select, 32'h80000000); end
      n_checks++; if (bus.in_ready !== (k == 3)) begin n_fail++; $display("FAIL long_ready[%0d] got=%b exp=%b", k, bus.in_ready, (k == 3)); end
      n_checks++; if (bus.done !== (k == 3)) begin n_fail++; $display("FAIL long_done[%0d] got=%b exp=%b", k, bus.done, (k == 3)); end
      @(negedge clk);
    end
    n_checks++; if (bus.select !== 32'h0 || bus.sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL long_end select=%h sel_valid=%b exp 0/0", bus.select, bus.sel_valid);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_sel [4];
    logic        exp_done[4];
    exp_sel[0] = 32'h20; exp_sel[1] = 32'h20; exp_sel[2] = 32'h40; exp_sel[3] = 32'h0;
    exp_done[0] = 1'b0;  exp_done[1] = 1'b1;  exp_done[2] = 1'b1;  exp_done[3] = 1'b0;
    bus.in_valid = 1'b1; bus.in_idx = 5'd5; bus.in_len = 8'd1;
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (bus.select !== exp_sel[k]) begin n_fail++; $display("FAIL b2b_select[%0d] got=%h exp=%h", k, bus.select, exp_sel[k]); end
      n_checks++; if (bus.done !== exp_done[k]) begin n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", k, bus.done, exp_done[k]); end
      if (k == 1) begin
        bus.in_valid = 1'b1; bus.in_idx = 5'd6; bus.in_len = 8'd0;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_hold();
    bus.in_valid = 1'b1; bus.in_idx = 5'd10; bus.in_len = 8'd20;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    n_checks++; if (bus.select !== 32'h00000400) begin n_fail++; $display("FAIL midrst_before got=%h exp=%h", bus.select, 32'h400); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.select !== 32'h0 || bus.sel_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async select=%h sel_valid=%b exp 0/0", bus.select, bus.sel_valid);
    end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.select !== 32'h0) begin
        n_fail++; $display("FAIL midrst_after[%0d] done=%b ready=%b select=%h exp 0/1/0", k, bus.done, bus.in_ready, bus.select);
      end
    end
  endtask

`ifdef PORT_MASK_SEL_EN
  task automatic test_masked_port();
    bus.port_mask = 32'h00000080;
    bus.in_valid = 1'b1; bus.in_idx = 5'd7; bus.in_len = 8'd2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mask_handshake got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (bus.drop !== 1'b1) begin n_fail++; $display("FAIL mask_drop got=%b exp=1", bus.drop); end
    n_checks++; if (bus.select !== 32'h0 || bus.sel_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mask_idle select=%h sel_valid=%b ready=%b exp 0/0/1", bus.select, bus.sel_valid, bus.in_ready);
    end
    @(negedge clk);
    n_checks++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL mask_drop_pulse got=%b exp=0", bus.drop); end
    bus.in_valid = 1'b1; bus.in_idx = 5'd8; bus.in_len = 8'd0;
    @(negedge clk);
    // Masked request arriving in the last hold cycle ends the hold.
    bus.in_valid = 1'b1; bus.in_idx = 5'd7; bus.in_len = 8'd0;
    n_checks++; if (bus.select !== 32'h00000100) begin n_fail++; $display("FAIL mask_grant8 got=%h exp=%h", bus.select, 32'h100); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (bus.select !== 32'h0 || bus.drop !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mask_last select=%h drop=%b ready=%b exp 0/1/1", bus.select, bus.drop, bus.in_ready);
    end
    bus.port_mask = '0;
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_cycle();
    test_long_hold();
    test_back_to_back();
    test_reset_mid_hold();
`ifdef PORT_MASK_SEL_EN
    test_masked_port();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
